mult_final_cpa_pipe: RTL
========================

Name: mult_final_cpa_pipe

Overview:
- Two-stage pipelined carry-propagate adder placed directly downstream of the 9-partial-product 4:2/3:2 compression tree in the 16x16 multiplier.
- Takes the tree's redundant output pair (sum row, carry row; the carry row is weighted <<1) and resolves it into the binary product.
- Splits the add at a parameterised bit boundary across two registered stages.
- Valid/ready handshake on both sides; sustains one result per cycle under no backpressure.

Parameters:
- WIDTH, 32, width of the tree's sum/carry rows and of the product.
- SPLIT, 16, number of low bits added in stage 1; legal range 1..WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  tree output pair is valid this cycle.
- in_ready  output  1  block accepts the pair this cycle.
- in_sum  input  WIDTH  sum row from the compression tree.
- in_carry  input  WIDTH  carry row from the compression tree, not yet shifted.
- out_valid  output  1  out_product is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_product  output  WIDTH  resolved product, modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1 of the final add.

Behaviour:
Clocking and reset
- Single clock. rst is synchronous and active-high.
- In any cycle with rst=1, the following clear at the next edge: s1_valid, s2_valid, out_product=0, out_cout=0, and all internal data registers=0. rst has priority over every other event.
- Reset mid-operation discards all in-flight operations. No partial result is ever presented.

Arithmetic
- Operand B = {in_carry[WIDTH-2:0], 1'b0}. in_carry[WIDTH-1] is discarded.
- Result = in_sum + B, computed at WIDTH+1 bits.
- out_product = result[WIDTH-1:0]; out_cout = result[WIDTH].

Stage 1, captured on the accept edge
- lo_sum = in_sum[SPLIT-1:0] + B[SPLIT-1:0], giving SPLIT bits plus carry c_mid.
- Registers: lo_sum, c_mid, in_sum[WIDTH-1:SPLIT], B[WIDTH-1:SPLIT].
- s1_valid is set.

Stage 2
- hi = in_sum_hi + B_hi + c_mid.
- Registers: out_product = {hi[WIDTH-SPLIT-1:0], lo_sum}; out_cout = hi[WIDTH-SPLIT]. s2_valid is set.
- out_valid = s2_valid.

Handshake (elastic pipeline, no combinational data path input to output)
- s2_ready = !s2_valid || out_ready.
- s1_ready = !s1_valid || s2_ready.
- in_ready = s1_ready.
- Accept at input when in_valid && in_ready. Transfer from stage 1 to stage 2 when s1_valid && s2_ready. Output retire when out_valid && out_ready.
- Latency: accept at edge N gives out_valid=1 after edge N+1, i.e. presented in the cycle following the second edge. Two cycles accept-to-output.
- Throughput: with out_ready held 1, one accept per cycle, back-to-back.

Stall and full conditions
- Stall: while out_valid && !out_ready, out_product and out_cout stay stable.
- Full: when both stages are valid and out_ready=0, in_ready=0. Stage 1 contents stay stable.
- Simultaneous events: retire at output, advance from stage 1 to stage 2, and new accept into stage 1 can all occur in the same cycle with no bubble.

Input and output contract
- Inputs are sampled only on accept. in_sum and in_carry may change freely while in_ready=0 or in_valid=0.
- No ordering change: results emerge in acceptance order.
- No X propagation: out_product is 0 until the first result is produced.

Test Plan:
- Split-crossing carry: in_sum=0x0000FFFF, in_carry=0x00000001, out_ready=1. Required: out_product=0x00010001 and out_cout=0, presented two cycles after accept.
- Full wrap: in_sum=0xFFFFFFFF, in_carry=0x00000001. Required: out_product=0x00000001, out_cout=1. A second test with in_carry=0x80000000 and in_sum=0 requires out_product=0x00000000 and out_cout=0, because the MSB of the carry row is discarded.
- Streaming: 8 back-to-back pairs, in_sum=k*0x1111, in_carry=k, for k=0..7, out_ready=1. Required: in_ready stays 1, eight consecutive out_valid cycles, and out_product=k*0x1111+2k in order.
- Backpressure: out_ready=0 for 5 cycles while 3 pairs are offered. Required: exactly 2 are accepted, in_ready drops to 0, and the output is held stable. After out_ready=1, all 3 results emerge in order with no loss or duplication.
- Reset mid-operation: accept 2 pairs, then assert rst for 1 cycle in the cycle where out_valid first rises. Required: out_valid=0, out_product=0, out_cout=0 at the next edge, neither pair ever appears, and in_ready=1 after reset.
- Random regression: 10k random pairs with random in_valid and out_ready. Required: every result equals (in_sum + (in_carry<<1)) mod 2^32 with matching cout, and the scoreboard order is preserved.

Source files
------------

// File: rtl/mult_final_cpa_pipe.sv
// Final carry-propagate adder behind the multiplier compression tree: resolves the
// redundant (sum, carry<<1) pair into the binary product over two elastic stages.
module mult_final_cpa_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_cout
);

  localparam int HI_W = WIDTH - SPLIT;

  function automatic logic [SPLIT:0] add_lo(input logic [SPLIT-1:0] a,
                                            input logic [SPLIT-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [HI_W:0] add_hi(input logic [HI_W-1:0] a,
                                           input logic [HI_W-1:0] b,
                                           input logic            ci);
    return {1'b0, a} + {1'b0, b} + {{HI_W{1'b0}}, ci};
  endfunction

  logic             vld_p1_q,    vld_p1_d;
  logic [SPLIT-1:0] lo_sum_p1_q, lo_sum_p1_d;
  logic             c_mid_p1_q,  c_mid_p1_d;
  logic [HI_W-1:0]  sum_hi_p1_q, sum_hi_p1_d;
  logic [HI_W-1:0]  b_hi_p1_q,   b_hi_p1_d;
  logic             vld_p2_q,    vld_p2_d;
  logic [WIDTH-1:0] prod_p2_q,   prod_p2_d;
  logic             cout_p2_q,   cout_p2_d;

  logic [WIDTH-1:0] b_full;
  logic [SPLIT:0]   lo_res;
  logic [HI_W:0]    hi_res;
  logic             s1_ready, s2_ready;
  logic             accept, advance;

  always_comb begin
    // The shift drops the carry-row MSB, which falls outside the product width.
    b_full   = in_carry << 1;
    lo_res   = add_lo(in_sum[SPLIT-1:0], b_full[SPLIT-1:0]);
    hi_res   = add_hi(sum_hi_p1_q, b_hi_p1_q, c_mid_p1_q);

    s2_ready = !vld_p2_q || out_ready;
    s1_ready = !vld_p1_q || s2_ready;
    accept   = in_valid && s1_ready;
    advance  = vld_p1_q && s2_ready;

    vld_p1_d    = vld_p1_q;
    lo_sum_p1_d = lo_sum_p1_q;
    c_mid_p1_d  = c_mid_p1_q;
    sum_hi_p1_d = sum_hi_p1_q;
    b_hi_p1_d   = b_hi_p1_q;
    vld_p2_d    = vld_p2_q;
    prod_p2_d   = prod_p2_q;
    cout_p2_d   = cout_p2_q;

    // Stage 1: low half of the add, upper operands parked for stage 2.
    if (accept) begin
      vld_p1_d    = 1'b1;
      lo_sum_p1_d = lo_res[SPLIT-1:0];
      c_mid_p1_d  = lo_res[SPLIT];
      sum_hi_p1_d = in_sum[WIDTH-1:SPLIT];
      b_hi_p1_d   = b_full[WIDTH-1:SPLIT];
    end else if (advance) begin
      vld_p1_d = 1'b0;
    end

    // Stage 2: upper half consumes the mid carry; holds while stalled downstream.
    if (advance) begin
      vld_p2_d  = 1'b1;
      prod_p2_d = {hi_res[HI_W-1:0], lo_sum_p1_q};
      cout_p2_d = hi_res[HI_W];
    end else if (out_ready) begin
      vld_p2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      lo_sum_p1_q <= '0;
      c_mid_p1_q  <= 1'b0;
      sum_hi_p1_q <= '0;
      b_hi_p1_q   <= '0;
      vld_p2_q    <= 1'b0;
      prod_p2_q   <= '0;
      cout_p2_q   <= 1'b0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      lo_sum_p1_q <= lo_sum_p1_d;
      c_mid_p1_q  <= c_mid_p1_d;
      sum_hi_p1_q <= sum_hi_p1_d;
      b_hi_p1_q   <= b_hi_p1_d;
      vld_p2_q    <= vld_p2_d;
      prod_p2_q   <= prod_p2_d;
      cout_p2_q   <= cout_p2_d;
    end
  end

  assign in_ready    = s1_ready;
  assign out_valid   = vld_p2_q;
  assign out_product = prod_p2_q;
  assign out_cout    = cout_p2_q;

endmodule
